booth_mul_sequencer: RTL and testbench

//  Upstream issue/capture stage for the sequential Radix-8 Booth multiplier.
//  - Accepts operand pairs over a valid/ready handshake and holds them stable on mul_a/mul_b.
//  - Pulses mul_start to launch one multiply, then waits a fixed LATENCY.
//  - Captures mul_product and presents it downstream over a valid/ready handshake.

---
 rtl/booth_mul_sequencer_if.sv | 28 ++
 rtl/booth_mul_sequencer.sv | 127 ++++++++++++
 tb/tb_booth_mul_sequencer.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/booth_mul_sequencer_if.sv
// Handshake and multiplier-side bus of the Booth multiply sequencer.
// slave = sequencer side, master = upstream/downstream/multiplier side.
interface booth_mul_sequencer_if #(
    parameter int unsigned WIDTH = 32
);
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       in_a;
    logic [WIDTH-1:0]       in_b;
    logic                   mul_start;
    logic [WIDTH-1:0]       mul_a;
    logic [WIDTH-1:0]       mul_b;
    logic [2*WIDTH-1:0]     mul_product;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*WIDTH-1:0]     out_product;
    logic                   busy;

    modport slave (
        input  in_valid, in_a, in_b, mul_product, out_ready,
        output in_ready, mul_start, mul_a, mul_b, out_valid, out_product, busy
    );

    modport master (
        output in_valid, in_a, in_b, mul_product, out_ready,
        input  in_ready, mul_start, mul_a, mul_b, out_valid, out_product, busy
    );
endinterface

// File: rtl/booth_mul_sequencer.sv
// Issue/capture sequencer for a fixed-latency sequential Booth multiplier.
// Optional accumulator enabled by defining BOOTH_SEQ_ACC_EN.
module booth_mul_sequencer #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned LATENCY = 12
) (
    input  logic                   clk,
    input  logic                   reset,
`ifdef BOOTH_SEQ_ACC_EN
    input  logic                   acc_clear,
    output logic [2*WIDTH-1:0]     acc_out,
`endif
    booth_mul_sequencer_if.slave   bus
);

    localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {StIdle, StLaunch, StWait, StHold} state_e;

    state_e               state_q;
    logic [CntW-1:0]      cnt_q;
    logic                 mul_start_q;
    logic                 out_valid_q;
    logic                 busy_q;
    logic [WIDTH-1:0]     mul_a_q;
    logic [WIDTH-1:0]     mul_b_q;
    logic [2*WIDTH-1:0]   out_product_q;
    logic                 accept;
    logic                 capture;

    // Ready is combinational from out_ready so HOLD can hand over to a new pair without a bubble.
    assign bus.in_ready = !reset &&
                          ((state_q == StIdle) || ((state_q == StHold) && bus.out_ready));
    assign accept       = bus.in_valid && bus.in_ready;
    assign capture      = (state_q == StWait) && (cnt_q == '0);

    assign bus.mul_start   = mul_start_q;
    assign bus.mul_a       = mul_a_q;
    assign bus.mul_b       = mul_b_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_product = out_product_q;
    assign bus.busy        = busy_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            mul_start_q   <= 1'b0;
            out_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            mul_a_q       <= '0;
            mul_b_q       <= '0;
            out_product_q <= '0;
        end else begin
            mul_start_q <= 1'b0;
            if (accept) begin
                mul_a_q <= bus.in_a;
                mul_b_q <= bus.in_b;
            end
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_q     <= StLaunch;
                        mul_start_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                StLaunch: begin
                    cnt_q   <= CntW'(LATENCY - 1);
                    state_q <= StWait;
                end
                StWait: begin
                    if (capture) begin
                        out_product_q <= bus.mul_product;
                        out_valid_q   <= 1'b1;
                        state_q       <= StHold;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                StHold: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        if (accept) begin
                            state_q     <= StLaunch;
                            mul_start_q <= 1'b1;
                        end else begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef BOOTH_SEQ_ACC_EN
    logic [2*WIDTH-1:0] acc_q;

    // A clear on a capture edge restarts the sum from the captured product.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
        end else if (capture) begin
            acc_q <= acc_clear ? bus.mul_product : acc_q + bus.mul_product;
        end else if (acc_clear) begin
            acc_q <= '0;
        end
    end

    assign acc_out = acc_q;
`endif

    a_start_one_cycle: assert property (@(posedge clk) disable iff (reset)
        mul_start_q |=> !mul_start_q);

    a_hold_stable: assert property (@(posedge clk) disable iff (reset)
        (state_q == StHold && !bus.out_ready) |=> $stable(out_product_q) && out_valid_q);

    a_operands_stable: assert property (@(posedge clk) disable iff (reset)
        (state_q != StIdle && !accept) |=> $stable(mul_a_q) && $stable(mul_b_q));

endmodule

// File: tb/tb_booth_mul_sequencer.sv
// Directed bench for booth_mul_sequencer with a fixed-latency multiplier model.
// Accumulator scenario runs only when BOOTH_SEQ_ACC_EN is defined.
module tb_booth_mul_sequencer;
    localparam int unsigned WIDTH   = 32;
    localparam int unsigned LATENCY = 12;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    booth_mul_sequencer_if #(.WIDTH(WIDTH)) bus ();

`ifdef BOOTH_SEQ_ACC_EN
    logic              acc_clear;
    logic [63:0]       acc_out;
`endif

    booth_mul_sequencer #(.WIDTH(WIDTH), .LATENCY(LATENCY)) dut (
        .clk       (clk),
        .reset     (reset),
`ifdef BOOTH_SEQ_ACC_EN
        .acc_clear (acc_clear),
        .acc_out   (acc_out),
`endif
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier model: product only becomes valid LATENCY cycles after the start pulse.
    logic signed [63:0] m_prod_q;
    logic [7:0]         m_cnt_q;
    logic               m_pend_q;
    initial begin
        m_prod_q = '0;
        m_cnt_q  = '0;
        m_pend_q = 1'b0;
    end
    always @(posedge clk) begin
        if (bus.mul_start) begin
            m_prod_q <= $signed(bus.mul_a) * $signed(bus.mul_b);
            m_cnt_q  <= 8'(LATENCY - 1);
            m_pend_q <= 1'b1;
        end else if (m_cnt_q != 0) begin
            m_cnt_q <= m_cnt_q - 8'd1;
        end
    end
    assign bus.mul_product = (m_pend_q && m_cnt_q == 0) ? m_prod_q : 64'hDEAD_BEEF_0BAD_F00D;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a pair and return one step after the accepting edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, output bit ok);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        #1;
        while (!bus.in_ready && n < 200) begin
            tick();
            n++;
        end
        ok = bus.in_ready;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic await_result(output int lat, output int starts, output bit ok);
        lat    = 0;
        starts = 0;
        while (!bus.out_valid && lat < 100) begin
            if (bus.mul_start) starts++;
            tick();
            lat++;
        end
        ok = bus.out_valid;
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic do_txn(input logic [31:0] a, input logic [31:0] b, output logic [63:0] prod,
                          output int lat, output int starts, output bit ok);
        bit ok_i, ok_r;
        issue(a, b, ok_i);
        await_result(lat, starts, ok_r);
        ok   = ok_i && ok_r;
        prod = bus.out_product;
        consume();
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        reset = 1'b0;
        #2 reset = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready);
        end
        checks++;
        if ({bus.mul_start, bus.out_valid, bus.busy} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got %b want 000",
                               {bus.mul_start, bus.out_valid, bus.busy});
        end
        checks++;
        if ({bus.mul_a, bus.mul_b, bus.out_product} !== 128'd0) begin
            errors++; $display("FAIL reset_data: got %h %h %h want 0", bus.mul_a, bus.mul_b,
                               bus.out_product);
        end
        repeat (3) tick();
        reset = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL idle_in_ready: got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_basic();
        logic [63:0] prod;
        int lat, starts;
        bit ok;
        issue(32'd5, 32'd3, ok);
        checks++;
        if (bus.mul_a !== 32'd5 || bus.mul_b !== 32'd3 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL basic_latch: got a=%0d b=%0d busy=%b want 5 3 1",
                               bus.mul_a, bus.mul_b, bus.busy);
        end
        await_result(lat, starts, ok);
        prod = bus.out_product;
        consume();
        checks++;
        if (!ok || lat != 13) begin
            errors++; $display("FAIL basic_latency: got %0d edges want 13", lat);
        end
        checks++;
        if (starts != 1) begin
            errors++; $display("FAIL basic_start_pulse: got %0d cycles want 1", starts);
        end
        checks++;
        if (prod !== 64'd15) begin
            errors++; $display("FAIL basic_product: got %0d want 15", prod);
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL basic_idle_after: got busy=%b valid=%b want 0 0",
                               bus.busy, bus.out_valid);
        end
    endtask

    task automatic test_extremes();
        logic [63:0] prod;
        int lat, starts;
        bit ok;
        do_txn(32'h8000_0000, 32'h8000_0000, prod, lat, starts, ok);
        checks++;
        if (!ok || prod !== 64'h4000_0000_0000_0000) begin
            errors++; $display("FAIL min_times_min: got %h want 4000000000000000", prod);
        end
    endtask

    task automatic test_hold();
        logic [63:0] prod;
        int lat, starts, bad;
        bit ok_i, ok_r;
        issue(32'h7FFF_FFFF, 32'h8000_0000, ok_i);
        await_result(lat, starts, ok_r);
        checks++;
        if (!ok_i || !ok_r || bus.out_product !== 64'hC000_0000_8000_0000) begin
            errors++; $display("FAIL hold_product: got %h want c000000080000000",
                               bus.out_product);
        end
        bus.in_valid = 1'b1;
        bus.in_a     = 32'hFFFF_FFFE;
        bus.in_b     = 32'd2;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus.out_product !== 64'hC000_0000_8000_0000 || bus.out_valid !== 1'b1 ||
                bus.in_ready !== 1'b0 || bus.mul_a !== 32'h7FFF_FFFF) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL hold_stable: got %0d bad cycles want 0", bad);
        end
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL hold_ready_comb: got %b want 1", bus.in_ready);
        end
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        checks++;
        if (bus.mul_start !== 1'b1 || bus.out_valid !== 1'b0 || bus.mul_a !== 32'hFFFF_FFFE) begin
            errors++; $display("FAIL hold_handover: got start=%b valid=%b a=%h want 1 0 fffffffe",
                               bus.mul_start, bus.out_valid, bus.mul_a);
        end
        await_result(lat, starts, ok_r);
        prod = bus.out_product;
        consume();
        checks++;
        if (!ok_r || lat != 13 || prod !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            errors++; $display("FAIL hold_next_result: got %h lat %0d want fffffffffffffffc 13",
                               prod, lat);
        end
    endtask

    task automatic test_reset_abort();
        logic [63:0] prod;
        int lat, starts, seen;
        bit ok;
        issue(32'd7, 32'd9, ok);
        repeat (6) tick();
        reset = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b0 ||
            bus.mul_a !== 32'd0) begin
            errors++; $display("FAIL abort_reset_state: got valid=%b busy=%b rdy=%b a=%h",
                               bus.out_valid, bus.busy, bus.in_ready, bus.mul_a);
        end
        tick();
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.out_valid) seen++;
            tick();
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL abort_no_result: got %0d valid cycles want 0", seen);
        end
        do_txn(32'd0, 32'hFFFF_FFFF, prod, lat, starts, ok);
        checks++;
        if (!ok || prod !== 64'd0 || lat != 13 || starts != 1) begin
            errors++; $display("FAIL abort_next: got %h lat %0d starts %0d want 0 13 1",
                               prod, lat, starts);
        end
    endtask

`ifdef BOOTH_SEQ_ACC_EN
    task automatic test_acc();
        logic [63:0] prod;
        int lat, starts;
        bit ok;
        acc_clear = 1'b1;
        tick();
        acc_clear = 1'b0;
        checks++;
        if (acc_out !== 64'd0) begin
            errors++; $display("FAIL acc_clear_idle: got %0d want 0", acc_out);
        end
        do_txn(32'd2, 32'd3, prod, lat, starts, ok);
        do_txn(32'd4, 32'd5, prod, lat, starts, ok);
        do_txn(32'hFFFF_FFFF, 32'd7, prod, lat, starts, ok);
        checks++;
        if (acc_out !== 64'd19) begin
            errors++; $display("FAIL acc_sum: got %0d want 19", acc_out);
        end
        issue(32'd6, 32'd6, ok);
        repeat (12) tick();
        acc_clear = 1'b1;
        tick();
        acc_clear = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || acc_out !== 64'd36) begin
            errors++; $display("FAIL acc_clear_capture: got valid=%b acc=%0d want 1 36",
                               bus.out_valid, acc_out);
        end
        consume();
    endtask
`endif

    task automatic test_random();
        logic [63:0] expq[$];
        logic [63:0] e;
        bit acc, cons;
        int sent, got, cyc, dups;
        sent = 0; got = 0; cyc = 0; dups = 0;
        bus.in_a     = $urandom;
        bus.in_b     = $urandom;
        bus.in_valid = 1'b1;
        while (got < 50 && cyc < 5000) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            acc  = bus.in_valid && bus.in_ready;
            cons = bus.out_valid && bus.out_ready;
            if (cons) begin
                got++;
                if (expq.size() == 0) begin
                    dups++;
                end else begin
                    e = expq.pop_front();
                    checks++;
                    if (bus.out_product !== e) begin
                        errors++; $display("FAIL random_%0d: got %h want %h", got,
                                           bus.out_product, e);
                    end
                end
            end
            if (acc) begin
                expq.push_back({{32{bus.in_a[31]}}, bus.in_a} * {{32{bus.in_b[31]}}, bus.in_b});
                sent++;
            end
            tick();
            cyc++;
            if (acc) begin
                if (sent < 50) begin
                    bus.in_a = $urandom;
                    bus.in_b = $urandom;
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        checks++;
        if (got != 50 || sent != 50 || dups != 0 || expq.size() != 0) begin
            errors++; $display("FAIL random_count: got %0d results %0d sent %0d extra want 50 50 0",
                               got, sent, dups);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
`ifdef BOOTH_SEQ_ACC_EN
        acc_clear = 1'b0;
`endif
        test_reset();
        test_basic();
        test_extremes();
        test_hold();
        test_reset_abort();
`ifdef BOOTH_SEQ_ACC_EN
        test_acc();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
